// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the command, alu-side and result-side signals of alu_issue_ctrl.
// slave is the issue block itself; master is whoever drives commands,
// supplies the alu response and consumes results.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SEL_W-1:0] in_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [SEL_W-1:0] out_sel;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, count
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Command FIFO + issue stage in front of a combinational alu. The FIFO head
// drives the alu directly; the alu response is captured into a one-entry
// result slot with its own valid/ready handshake.
module alu_issue_ctrl #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } cmd_t;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_y;
  logic [SEL_W-1:0] r_out_sel;

  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_nonempty;
  cmd_t w_head;

  // No full bypass: a pop in the same cycle does not open a slot when full.
  assign w_in_ready = (r_count < CNT_W'(DEPTH)) && !rst;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && (!r_out_valid || bus.out_ready);
  assign w_head     = w_nonempty ? r_mem[r_rptr] : '0;

  assign bus.in_ready  = w_in_ready;
  assign bus.alu_a     = w_head.a;
  assign bus.alu_b     = w_head.b;
  assign bus.alu_sel   = w_head.sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_sel   = r_out_sel;
  assign bus.count     = r_count;

  // FIFO storage write; contents need no reset since count gates the head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{sel: bus.in_sel, b: bus.in_b, a: bus.in_a};
  end

  // Pointers, occupancy and the result slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_sel   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_y     <= bus.alu_y;
        r_out_sel   <= w_head.sel;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised + directed bench for alu_issue_ctrl. A behavioural alu closes
// the loop; a queue-based model of FIFO + result slot predicts every output.
module tb_alu_issue_ctrl;
  localparam int WIDTH = 4;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) bus ();

  alu_issue_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] alu_f(input logic [3:0] a, b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 4'd0;
    endcase
  endfunction

  assign bus.alu_y = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  cmd_t       q[$];
  logic       m_sv  = 1'b0;
  logic [3:0] m_y   = '0;
  logic [2:0] m_sel = '0;
  logic [3:0] got[$];

  // One clock: drive at negedge, check every output, advance the model.
  task automatic step(input logic r, input logic v, input logic [3:0] a, b,
                      input logic [2:0] s, input logic ordy);
    logic exp_rdy, push, pop;
    cmd_t c;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_sel = s;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !r && (q.size() < DEPTH);
    chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    chk("count",     32'(bus.count),     32'(q.size()));
    chk("alu_a",     32'(bus.alu_a),     32'(q.size() ? q[0].a   : 4'd0));
    chk("alu_b",     32'(bus.alu_b),     32'(q.size() ? q[0].b   : 4'd0));
    chk("alu_sel",   32'(bus.alu_sel),   32'(q.size() ? q[0].sel : 3'd0));
    chk("out_valid", 32'(bus.out_valid), 32'(m_sv));
    chk("out_y",     32'(bus.out_y),     32'(m_y));
    chk("out_sel",   32'(bus.out_sel),   32'(m_sel));
    if (bus.out_valid && ordy) got.push_back(bus.out_y);
    push = v && exp_rdy;
    pop  = (q.size() > 0) && (!m_sv || ordy);
    @(posedge clk);
    if (r) begin
      q.delete(); m_sv = 1'b0; m_y = '0; m_sel = '0;
    end else begin
      if (pop) begin
        c = q.pop_front();
        m_sv = 1'b1; m_y = alu_f(c.a, c.b, c.sel); m_sel = c.sel;
      end else if (ordy) m_sv = 1'b0;
      if (push) begin
        c.a = a; c.b = b; c.sel = s;
        q.push_back(c);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, ordy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
  endtask

  logic [3:0] exp_seq [5];
  int base;

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_sel = '0; bus.out_ready = 1'b0;
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
    exp_seq[3] = 4'b0111; exp_seq[4] = 4'b1010;

    // Directed opcode sweep, A=0101 B=0011
    do_reset();
    base = got.size();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b0101, 4'b0011, 3'(i), 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("sweep_len", 32'(got.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < got.size()) chk("sweep_y", 32'(got[base + i]), 32'(exp_seq[i]));

    // Backpressure: 6 offered, 5 held (slot + 4 queued)
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0101, 4'b0011, 3'(i % 5), 1'b0);
    #1;
    chk("bp_count", 32'(bus.count), 32'd4);
    chk("bp_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_y",     32'(bus.out_y), 32'b1000);
    idle(1'b0);
    base = got.size();
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("bp_drain", 32'(got.size() - base), 32'd5);

    // Reset with 3 queued and a pending result
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd3, 4'd1, 3'd1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovld",  32'(bus.out_valid), 32'd0);
    chk("rst_y",     32'(bus.out_y), 32'd0);
    base = got.size();
    step(1'b0, 1'b1, 4'b0001, 4'b0001, 3'd0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("cold_len", 32'(got.size() - base), 32'd1);
    if (got.size() > base) chk("cold_y", 32'(got[base]), 32'b0010);

    // Random traffic, occasional reset
    do_reset();
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 3) != 0,
           4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_empty", 32'(bus.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream command buffer and issue stage for the combinational 4-bit alu. It accepts operation commands (A, B, sel) over a valid/ready handshake and queues them in a small FIFO. It presents the FIFO head to the alu's A/B/sel inputs and captures the alu's Y into a registered result slot with its own valid/ready handshake toward the consumer.

Parameters:
WIDTH, 4, operand/result width; must match alu A/B/Y width
SEL_W, 3, opcode width; must match alu sel width
DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  command present on in_a/in_b/in_sel
in_ready  output  1  block can accept a command this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sel  input  SEL_W  opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A)
alu_a  output  WIDTH  to alu A
alu_b  output  WIDTH  to alu B
alu_sel  output  SEL_W  to alu sel
alu_y  input  WIDTH  from alu Y (combinational response to alu_a/alu_b/alu_sel)
out_valid  output  1  result slot holds a result
out_ready  input  1  consumer takes result this cycle
out_y  output  WIDTH  captured alu result
out_sel  output  SEL_W  opcode that produced out_y
count  output  clog2(DEPTH)+1  commands currently queued in the FIFO, excluding the result slot

Behaviour:
- Reset (rst=1 at a clock edge): count=0, FIFO pointers=0, out_valid=0, out_y=0, out_sel=0. in_ready is 0 while rst is high.
- Push: occurs when in_valid && in_ready. in_ready = (count < DEPTH) && !rst. There is no same-cycle full bypass: when count==DEPTH, in_ready=0 even if a pop happens that cycle.
- alu_a/alu_b/alu_sel are driven combinationally from the FIFO head when count>0, and are all-zero when count==0.
- Issue (pop): occurs when count>0 && (!out_valid || out_ready).
  - On issue: out_y<=alu_y, out_sel<=head sel, out_valid<=1, read pointer advances.
- Result slot:
  - out_valid && out_ready with no issue: out_valid<=0; out_y and out_sel hold their values.
  - out_valid && !out_ready: out_y, out_sel and out_valid are held stable. No issue occurs.
- Latency: a command accepted at edge N is at the head after N. It is issued at edge N+1, so out_valid=1 after N+1 (2 cycles), provided the slot is free and the command is the only one queued.
- Throughput: one command per cycle sustained when out_ready=1 and in_valid=1.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Commands leave in strict FIFO order. No command is dropped or duplicated.
- Maximum buffering is DEPTH+1 commands (FIFO plus result slot).
- Reset mid-operation discards all queued commands and any pending result. The first post-reset command behaves as from cold start.
- Arithmetic is performed entirely by the alu. This block never modifies operand or result widths.

Test Plan:
- After reset, push A=0101,B=0011 with sel=000, 001, 010, 011, 100 on consecutive cycles, out_ready=1 -> out_y sequence 1000, 0010, 0001, 0111, 1010 with matching out_sel. First out_valid occurs 2 cycles after the first accept, then one result per cycle.
- Backpressure: out_ready=0, push 6 commands -> 5 accepted (1 in slot + 4 queued), count=4, in_ready=0. out_y stays 1000 and stable until out_ready=1, then drains in order.
- Wrap-around: 10 back-to-back commands with random out_ready -> all 10 results in order. A scoreboard must match alu behaviour, with no loss or duplication.
- Simultaneous push/pop at count=2 -> count stays 2. At count=DEPTH -> in_ready=0 that cycle.
- Empty: count=0 -> alu_a=alu_b=0, alu_sel=000, out_valid falls after the last result is consumed.
- Reset with 3 queued and out_valid=1 -> next cycle count=0, out_valid=0, out_y=0. A new command A=0001,B=0001,sel=000 yields out_y=0010.
